fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write arbiter that shares the single write port of the 8-bit synchronous FIFO between two producers. Each producer requests ownership, receives a registered grant, and streams words into the FIFO for a bounded burst before ownership is re-arbitrated. The block drives the FIFO's write enable and data input directly and observes its full flag. Read-side control remains with the FIFO's consumer.

## Interface
- WIDTH, 8, data word width; matches the FIFO data width.
- BURST, 4, maximum words accepted per grant; legal range 1..15.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- req0  input  1  producer 0 has a valid word on data0.
- data0  input  WIDTH  producer 0 write data.
- req1  input  1  producer 1 has a valid word on data1.
- data1  input  WIDTH  producer 1 write data.
- fifo_full  input  1  FIFO full flag.
- gnt0  output  1  registered; producer 0 owns the FIFO write port.
- gnt1  output  1  registered; producer 1 owns the FIFO write port.
- fifo_wr_en  output  1  combinational write enable to the FIFO.
- fifo_din  output  WIDTH  combinational write data to the FIFO.

## Operation
- States: IDLE, OWN0, OWN1. gnt0 = (state == OWN0) and gnt1 = (state == OWN1), decoded from registered state.
- Round-robin pointer `last` records the most recently granted producer.
- Acceptance: accN = gntN & reqN & ~fifo_full. fifo_wr_en = acc0 | acc1. fifo_din = data0 when gnt0, data1 when gnt1, otherwise 0.
- The burst counter `cnt` (4 bits) increments on each acceptance and clears on each state change.
- IDLE: with no requests, stay in IDLE. With a single request, grant that producer. With both requesting, grant the producer that is not `last`.
- OWNn releases ownership at the clock edge where either:
  - the accepted word is the BURST-th of the grant (cnt == BURST-1 and accN), or
  - reqN is low.
- On release, the next state follows the same IDLE arbitration using the current req0/req1, with the releasing producer as `last`. Handoff goes directly from OWN0 to OWN1 with no IDLE bubble. If the releasing producer is the only requester, it is re-granted with cnt cleared.
- When fifo_full = 1, nothing is accepted, cnt holds, and the grant holds. Ownership is released only if the owner drops its req.
- `last` updates to n on every entry into OWNn.
- Words are never dropped or duplicated. A producer must hold dataN stable while reqN is high until it observes acceptance.

## Timing
- Reset values: state = IDLE, last = 1 (producer 0 wins the first tie), cnt = 0, gnt0 = gnt1 = 0. fifo_wr_en = 0 and fifo_din = 0 follow from reset state.
- Request-to-grant latency: a req rising in cycle t while IDLE gives a grant in cycle t+1. The first FIFO write is sampled at the end of cycle t+1.
- Throughput: one word per cycle while granted and not full. A full burst occupies exactly BURST grant cycles.
- Handoff: the cycle after the BURST-th word of OWN0 shows gnt1 = 1 if req1 is high. No dead cycle.
- rst asserted in any state takes effect at that edge and overrides all transitions. fifo_wr_en is 0 from the following cycle. A word accepted in the cycle rst is sampled is still written by the FIFO; the FIFO's own reset clears it.
- Simultaneous owner release and fifo_full: release occurs only through req drop, and no word is counted.

## Test plan
- Reset: hold rst for 2 cycles with both reqs high. Gnt0 = gnt1 = fifo_wr_en = 0 throughout. Gnt0 = 1 in the cycle after rst falls.
- Single producer: req0 with data 1, 2, 3, 4, 5 (BURST=4). FIFO receives 1, 2, 3, 4. Gnt0 drops for exactly 0 cycles (re-grant), then 5 is written. gnt1 is never asserted.
- Contention: req0 and req1 held high continuously. Grants alternate in blocks of 4 words, 0 first, with fifo_wr_en high every cycle after the first grant.
- Full stall: fifo_full asserted for 3 cycles mid-burst of producer 1 after 2 words. fifo_wr_en = 0 and gnt1 holds. After full clears, exactly 2 more words are written before handoff.
- Early release: producer 0 drops req0 after 1 word while req1 is high. Gnt1 = 1 in the next cycle. Later, with both requesting from IDLE, producer 0 wins because last = 1.
- Mid-burst reset: assert rst during OWN1 after 2 words. The next cycle is IDLE with all outputs 0, and arbitration restarts with producer 0 as the tie winner.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin owner of the FIFO write port for two producers. A grant lasts
// until the owner has had BURST words accepted or drops its request. Ownership
// then passes straight to the next requester, with no idle cycle in between.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no owner, fifo_wr_en and fifo_din held at 0
//   OWN0  | producer 0 owns the write port (gnt0 = 1)
//   OWN1  | producer 1 owns the write port (gnt1 = 1)
module fifo_wr_arbiter #(
    parameter int WIDTH = 8,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    input  logic             fifo_full,
    output logic             gnt0,
    output logic             gnt1,
    output logic             fifo_wr_en,
    output logic [WIDTH-1:0] fifo_din
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    // cnt_q counts the words accepted so far in the current grant; the
    // BURST-th acceptance is the one seen while cnt_q == BURST-1.
    localparam logic [3:0] CNT_LAST = 4'(BURST - 1);

    state_t     state_q, state_d;
    logic       last_q, last_d;
    logic [3:0] cnt_q, cnt_d;

    logic acc0;
    logic acc1;
    logic release_own;

    // Shared arbitration used from IDLE and on every release. On a tie the
    // winner is the producer that is not 'last'.
    function automatic state_t arbitrate(input logic r0, input logic r1,
                                         input logic last);
        state_t nxt;
        if (r0 && r1) begin
            nxt = last ? OWN0 : OWN1;
        end else if (r0) begin
            nxt = OWN0;
        end else if (r1) begin
            nxt = OWN1;
        end else begin
            nxt = IDLE;
        end
        return nxt;
    endfunction

    // Grants come straight from the registered state; acceptance and the
    // write port are combinational from the grants and the current inputs.
    always_comb begin
        gnt0       = (state_q == OWN0);
        gnt1       = (state_q == OWN1);
        acc0       = gnt0 & req0 & ~fifo_full;
        acc1       = gnt1 & req1 & ~fifo_full;
        fifo_wr_en = acc0 | acc1;
        if (gnt0) begin
            fifo_din = data0;
        end else if (gnt1) begin
            fifo_din = data1;
        end else begin
            fifo_din = '0;
        end
    end

    // Next-state, round-robin pointer and burst counter.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        release_own = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = arbitrate(req0, req1, last_q);
            end
            OWN0: begin
                // While full, acc0 is 0, so only a dropped request can release.
                if (!req0 || (acc0 && (cnt_q == CNT_LAST))) begin
                    release_own = 1'b1;
                    state_d     = arbitrate(req0, req1, 1'b0);
                end
            end
            OWN1: begin
                if (!req1 || (acc1 && (cnt_q == CNT_LAST))) begin
                    release_own = 1'b1;
                    state_d     = arbitrate(req0, req1, 1'b1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A release clears the count even when the same producer is
        // re-granted, so a re-grant starts a fresh burst.
        if (release_own || (state_q == IDLE)) begin
            cnt_d = '0;
        end else if (acc0 || acc1) begin
            cnt_d = cnt_q + 4'd1;
        end

        if (state_d == OWN0) begin
            last_d = 1'b0;
        end else if (state_d == OWN1) begin
            last_d = 1'b1;
        end
    end

    // State registers. Reset is synchronous and beats every transition.
    // last resets to 1 so that producer 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (WIDTH=8, BURST=4). Each step drives one
// cycle of inputs, states the grants and write enable expected in that cycle,
// and pushes the word the FIFO should receive. A write monitor pops and
// compares that word whenever fifo_wr_en is seen.
module tb_fifo_wr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, fifo_full;
    logic [7:0] data0, data1;
    logic       gnt0, gnt1, fifo_wr_en;
    logic [7:0] fifo_din;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];

    fifo_wr_arbiter #(.WIDTH(8), .BURST(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0       (req0),
        .data0      (data0),
        .req1       (req1),
        .data1      (data1),
        .fifo_full  (fifo_full),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Write monitor: every word written must be the next expected one.
    always @(negedge clk) begin
        if (fifo_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", fifo_din, 8'hxx);
            end else begin
                chk("fifo_din", fifo_din, exp_q.pop_front());
            end
        end
    end

    task automatic step(input logic r,
                        input logic r0, input logic [7:0] d0,
                        input logic r1, input logic [7:0] d1,
                        input logic f,
                        input logic eg0, input logic eg1, input logic ewe,
                        input logic [7:0] edin);
        rst       = r;
        req0      = r0;
        data0     = d0;
        req1      = r1;
        data1     = d1;
        fifo_full = f;
        if (ewe) exp_q.push_back(edin);
        @(negedge clk);
        chk("gnt0", {7'd0, gnt0}, {7'd0, eg0});
        chk("gnt1", {7'd0, gnt1}, {7'd0, eg1});
        chk("fifo_wr_en", {7'd0, fifo_wr_en}, {7'd0, ewe});
        if (!eg0 && !eg1) chk("din_idle", fifo_din, 8'h00);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1; fifo_full = 1'b0;
        data0 = 8'h00; data1 = 8'h00;
        @(posedge clk);
        #1;

        // reset held with both requests high
        step(1, 1, 8'h00, 1, 8'h00, 0,  0, 0, 0, 8'h00);
        step(1, 1, 8'h00, 1, 8'h00, 0,  0, 0, 0, 8'h00);

        // contention: blocks of 4, producer 0 first, no dead cycle
        step(0, 1, 8'hA0, 1, 8'hB0, 0,  0, 0, 0, 8'h00);
        step(0, 1, 8'hA0, 1, 8'hB0, 0,  1, 0, 1, 8'hA0);
        step(0, 1, 8'hA1, 1, 8'hB0, 0,  1, 0, 1, 8'hA1);
        step(0, 1, 8'hA2, 1, 8'hB0, 0,  1, 0, 1, 8'hA2);
        step(0, 1, 8'hA3, 1, 8'hB0, 0,  1, 0, 1, 8'hA3);
        step(0, 1, 8'hA4, 1, 8'hB0, 0,  0, 1, 1, 8'hB0);
        step(0, 1, 8'hA4, 1, 8'hB1, 0,  0, 1, 1, 8'hB1);
        step(0, 1, 8'hA4, 1, 8'hB2, 0,  0, 1, 1, 8'hB2);
        step(0, 1, 8'hA4, 1, 8'hB3, 0,  0, 1, 1, 8'hB3);
        step(0, 1, 8'hA4, 1, 8'hB4, 0,  1, 0, 1, 8'hA4);

        // early release: producer 0 drops after one word, gnt1 next cycle
        step(0, 0, 8'h00, 1, 8'hB4, 0,  1, 0, 0, 8'h00);

        // full stall after 2 words of producer 1, then exactly 2 more
        step(0, 0, 8'h00, 1, 8'hB4, 0,  0, 1, 1, 8'hB4);
        step(0, 0, 8'h00, 1, 8'hB5, 0,  0, 1, 1, 8'hB5);
        step(0, 0, 8'h00, 1, 8'hB6, 1,  0, 1, 0, 8'h00);
        step(0, 0, 8'h00, 1, 8'hB6, 1,  0, 1, 0, 8'h00);
        step(0, 0, 8'h00, 1, 8'hB6, 1,  0, 1, 0, 8'h00);
        step(0, 0, 8'h00, 1, 8'hB6, 0,  0, 1, 1, 8'hB6);
        step(0, 0, 8'h00, 1, 8'hB7, 0,  0, 1, 1, 8'hB7);
        // sole requester re-granted with a fresh burst, then both drop
        step(0, 0, 8'h00, 0, 8'h00, 0,  0, 1, 0, 8'h00);
        step(0, 0, 8'h00, 0, 8'h00, 0,  0, 0, 0, 8'h00);
        // tie from IDLE with last = 1: producer 0 wins
        step(0, 1, 8'hA5, 1, 8'hB8, 0,  0, 0, 0, 8'h00);
        step(0, 1, 8'hA5, 1, 8'hB8, 0,  1, 0, 1, 8'hA5);
        step(0, 0, 8'h00, 0, 8'h00, 0,  1, 0, 0, 8'h00);

        // single producer, 5 words: 1..4, re-grant with no gap, then 5
        step(0, 1, 8'h01, 0, 8'h00, 0,  0, 0, 0, 8'h00);
        step(0, 1, 8'h01, 0, 8'h00, 0,  1, 0, 1, 8'h01);
        step(0, 1, 8'h02, 0, 8'h00, 0,  1, 0, 1, 8'h02);
        step(0, 1, 8'h03, 0, 8'h00, 0,  1, 0, 1, 8'h03);
        step(0, 1, 8'h04, 0, 8'h00, 0,  1, 0, 1, 8'h04);
        step(0, 1, 8'h05, 0, 8'h00, 0,  1, 0, 1, 8'h05);
        step(0, 0, 8'h00, 0, 8'h00, 0,  1, 0, 0, 8'h00);
        step(0, 0, 8'h00, 0, 8'h00, 0,  0, 0, 0, 8'h00);

        // mid-burst reset during OWN1 after 2 words
        step(0, 0, 8'h00, 1, 8'hC0, 0,  0, 0, 0, 8'h00);
        step(0, 0, 8'h00, 1, 8'hC0, 0,  0, 1, 1, 8'hC0);
        step(0, 0, 8'h00, 1, 8'hC1, 0,  0, 1, 1, 8'hC1);
        step(1, 1, 8'hD0, 1, 8'hC2, 0,  0, 1, 1, 8'hC2);
        step(0, 1, 8'hD0, 1, 8'hC2, 0,  0, 0, 0, 8'h00);
        step(0, 1, 8'hD0, 1, 8'hC2, 0,  1, 0, 1, 8'hD0);
        step(0, 0, 8'h00, 0, 8'h00, 0,  1, 0, 0, 8'h00);

        chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
